// File: rtl/wb_slave_interconnect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xm_wb_pkg
// Purpose  : Shared types and sizing helpers for the Wishbone slave
//            interconnect and its watchdog.
// Revision : 1.0 - initial release
// ============================================================================
package xm_wb_pkg;

   // Interconnect FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2,
      ST_ERROR  = 2'd3
   } wb_ic_state_t;

   // Width of the slave-index field; never narrower than one bit.
   function automatic int idx_width(input int slaves);
      return (slaves > 1) ? $clog2(slaves) : 1;
   endfunction

   // Width of the watchdog counter, wide enough to hold TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_slave_interconnect_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_interconnect_if
// Purpose  : Master-side Wishbone bus bundle of the slave interconnect.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_slave_interconnect_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic                  cyc_i;
   logic                  stb_i;
   logic                  we_i;
   logic [DATA_W/8-1:0]   sel_i;
   logic [ADDR_W-1:0]     adr_i;
   logic [DATA_W-1:0]     dat_i;
   logic                  ack_o;
   logic                  err_o;
   logic [DATA_W-1:0]     dat_o;

   // Seen from the interconnect.
   modport slave (
      input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
      output ack_o, err_o, dat_o
   );

   // Seen from the bus master.
   modport master (
      output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
      input  ack_o, err_o, dat_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_slave_interconnect_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_watchdog
// Purpose  : Counts enabled cycles since the last clear and flags the cycle
//            in which the count reaches TIMEOUT. TIMEOUT=0 disables it.
// Revision : 1.0 - initial release
// ============================================================================
module wb_watchdog
   import xm_wb_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = cnt_width(TIMEOUT);

   generate
      if (TIMEOUT > 0) begin : g_wd_on
         localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
         localparam logic [CNT_W-1:0] c_sat  = CNT_W'(TIMEOUT);

         // r_cnt holds completed enabled cycles, so the current one is r_cnt+1.
         logic [CNT_W-1:0] r_cnt;

         // Saturating counter, cleared while idle.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
               r_cnt <= '0;
            else if (clear)
               r_cnt <= '0;
            else if (enable && (r_cnt != c_sat))
               r_cnt <= r_cnt + CNT_W'(1);
         end

         assign expired = enable && (r_cnt >= c_last);
      end else begin : g_wd_off
         assign expired = 1'b0;
      end
   endgenerate
endmodule
`default_nettype wire

// File: rtl/wb_slave_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_interconnect
// Purpose  : One Wishbone master to SLAVES slaves, decoded by an address
//            field at SEL_H, with registered read data, bus-error on bad
//            index and an optional ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_slave_interconnect
   import xm_wb_pkg::*;
#(
   parameter int SLAVES  = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int SEL_H   = 12,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   wb_slave_interconnect_if.slave     mst,
   output logic [SLAVES-1:0]          slvCyc_o,
   output logic [SLAVES-1:0]          slvStb_o,
   input  logic [SLAVES-1:0]          slvAck_i,
   input  logic [SLAVES*DATA_W-1:0]   slvDat_i,
   output logic [ADDR_W-1:0]          adr_o,
   output logic                       we_o,
   output logic [DATA_W/8-1:0]        sel_o,
   output logic [DATA_W-1:0]          dat_o_slv,
   output logic                       busy_o
);
   localparam int IDX_W = idx_width(SLAVES);

   wb_ic_state_t        r_state;
   wb_ic_state_t        w_next;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_req_idx;
   logic [DATA_W-1:0]   r_dat;
   logic [DATA_W-1:0]   w_slv_dat;
   logic                w_slv_ack;
   logic                w_req;
   logic                w_expired;

   assign w_req     = mst.cyc_i & mst.stb_i;
   assign w_req_idx = mst.adr_i[SEL_H +: IDX_W];

   // Write-side signals go to every slave untouched.
   assign we_o      = mst.we_i;
   assign sel_o     = mst.sel_i;
   assign dat_o_slv = mst.dat_i;
   assign mst.dat_o = r_dat;

   generate
      if (SEL_H >= ADDR_W) begin : g_adr_full
         assign adr_o = mst.adr_i;
      end else begin : g_adr_mask
         assign adr_o = {{(ADDR_W-SEL_H){1'b0}}, mst.adr_i[SEL_H-1:0]};
      end
   endgenerate

   // Pick ack and read data of the latched slave; other acks are ignored.
   always_comb begin
      w_slv_ack = 1'b0;
      w_slv_dat = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_slv_ack = slvAck_i[i];
            w_slv_dat = slvDat_i[i*DATA_W +: DATA_W];
         end
      end
   end

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (r_state == ST_IDLE),
      .enable  (r_state == ST_ACTIVE),
      .expired (w_expired)
   );

   // State, latched slave index and captured read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_dat   <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == ST_IDLE) && w_req)
            r_idx <= w_req_idx;
         if ((r_state == ST_ACTIVE) && mst.cyc_i && w_slv_ack)
            r_dat <= w_slv_dat;
      end
   end

   // Next state and all state-decoded outputs; abort beats ack beats timeout.
   always_comb begin
      w_next      = r_state;
      slvCyc_o    = '0;
      slvStb_o    = '0;
      mst.ack_o   = 1'b0;
      mst.err_o   = 1'b0;
      busy_o      = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_req)
               w_next = (int'(w_req_idx) < SLAVES) ? ST_ACTIVE : ST_ERROR;
         end
         ST_ACTIVE: begin
            for (int i = 0; i < SLAVES; i++) begin
               if (r_idx == IDX_W'(i)) begin
                  slvCyc_o[i] = mst.cyc_i;
                  slvStb_o[i] = mst.cyc_i & mst.stb_i;
               end
            end
            if (!mst.cyc_i)
               w_next = ST_IDLE;
            else if (w_slv_ack)
               w_next = ST_RESP;
            else if (w_expired)
               w_next = ST_ERROR;
         end
         ST_RESP: begin
            mst.ack_o = 1'b1;
            w_next    = ST_IDLE;
         end
         ST_ERROR: begin
            mst.err_o = 1'b1;
            w_next    = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_wb_slave_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_slave_interconnect
// Purpose  : Directed self-checking bench for wb_slave_interconnect with
//            three slaves and an eight-cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_slave_interconnect;
   localparam int SLAVES  = 3;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int SEL_H   = 12;
   localparam int TIMEOUT = 8;

   logic                     clk;
   logic                     rst;
   logic [SLAVES-1:0]        slv_cyc;
   logic [SLAVES-1:0]        slv_stb;
   logic [SLAVES-1:0]        slv_ack;
   logic [SLAVES*DATA_W-1:0] slv_dat;
   logic [ADDR_W-1:0]        adr_o;
   logic                     we_o;
   logic [DATA_W/8-1:0]      sel_o;
   logic [DATA_W-1:0]        dat_o_slv;
   logic                     busy;

   int n_tests = 0;
   int n_fail  = 0;

   wb_slave_interconnect_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   wb_slave_interconnect #(
      .SLAVES  (SLAVES),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .SEL_H   (SEL_H),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .mst       (bus),
      .slvCyc_o  (slv_cyc),
      .slvStb_o  (slv_stb),
      .slvAck_i  (slv_ack),
      .slvDat_i  (slv_dat),
      .adr_o     (adr_o),
      .we_o      (we_o),
      .sel_o     (sel_o),
      .dat_o_slv (dat_o_slv),
      .busy_o    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start of a new cycle: just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [15:0] adr, input logic we, input logic [15:0] dat,
                            input logic [1:0] sel);
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = we;
      bus.adr_i = adr;
      bus.dat_i = dat;
      bus.sel_i = sel;
   endtask

   task automatic idle_bus();
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
   endtask

   // Read where the slave acks on its first strobe cycle.
   task automatic read_txn(input string tag, input logic [15:0] adr, input int slv,
                           input logic [15:0] data, input logic [2:0] exp_stb);
      step(); drive_req(adr, 1'b0, 16'h0000, 2'b11);
      @(negedge clk);
      step(); slv_ack = exp_stb; slv_dat[slv*DATA_W +: DATA_W] = data;
      @(negedge clk);
      check_eq({tag, "_stb"}, slv_stb, exp_stb);
      check_eq({tag, "_ack_early"}, bus.ack_o, 1'b0);
      step(); slv_ack = '0;
      @(negedge clk);
      check_eq({tag, "_ack"}, bus.ack_o, 1'b1);
      check_eq({tag, "_dat"}, bus.dat_o, data);
      step(); idle_bus();
      @(negedge clk);
      check_eq({tag, "_busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int acks;
      int errs;
      int stb_ok;

      rst     = 1'b1;
      slv_ack = '0;
      slv_dat = '0;
      bus.sel_i = '0;
      bus.adr_i = '0;
      bus.dat_i = '0;
      idle_bus();

      // Reset state.
      @(negedge clk);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_ack_err", {bus.ack_o, bus.err_o}, 2'b00);
      check_eq("rst_slv", {slv_cyc, slv_stb}, 6'b0);
      check_eq("rst_dat", bus.dat_o, 16'h0000);
      step(); rst = 1'b0;

      // Read from slave 1 with local-address masking.
      step(); drive_req(16'h1004, 1'b0, 16'h0000, 2'b11);
      @(negedge clk);
      check_eq("rd_adr_o", adr_o, 16'h0004);
      check_eq("rd_c0_stb", slv_stb, 3'b000);
      step(); slv_ack = 3'b010; slv_dat[31:16] = 16'hBEEF;
      @(negedge clk);
      check_eq("rd_c1_stb", slv_stb, 3'b010);
      check_eq("rd_c1_cyc", slv_cyc, 3'b010);
      check_eq("rd_c1_ack", bus.ack_o, 1'b0);
      step(); slv_ack = '0;
      @(negedge clk);
      check_eq("rd_c2_ack", bus.ack_o, 1'b1);
      check_eq("rd_c2_err", bus.err_o, 1'b0);
      check_eq("rd_c2_dat", bus.dat_o, 16'hBEEF);
      check_eq("rd_c2_stb", slv_stb, 3'b000);
      step(); idle_bus();
      @(negedge clk);
      check_eq("rd_c3_ack", bus.ack_o, 1'b0);
      check_eq("rd_c3_busy", busy, 1'b0);

      // Write to slave 0; slave returns 0x5A5A on its data lines.
      acks = 0;
      step(); drive_req(16'h0010, 1'b1, 16'h1234, 2'b01);
      @(negedge clk);
      check_eq("wr_adr_o", adr_o, 16'h0010);
      step(); slv_ack = 3'b001; slv_dat[15:0] = 16'h5A5A;
      @(negedge clk);
      check_eq("wr_stb", slv_stb, 3'b001);
      check_eq("wr_we", we_o, 1'b1);
      check_eq("wr_dat", dat_o_slv, 16'h1234);
      check_eq("wr_sel", sel_o, 2'b01);
      acks += int'(bus.ack_o);
      step(); slv_ack = '0;
      @(negedge clk); acks += int'(bus.ack_o);
      step(); idle_bus();
      @(negedge clk); acks += int'(bus.ack_o);
      step();
      @(negedge clk); acks += int'(bus.ack_o);
      check_eq("wr_ack_pulses", acks, 1);

      // Index 3 does not exist: immediate bus error, dat_o kept.
      step(); drive_req(16'h3000, 1'b0, 16'h0000, 2'b11);
      @(negedge clk);
      step();
      @(negedge clk);
      check_eq("bad_stb", {slv_cyc, slv_stb}, 6'b0);
      check_eq("bad_err", bus.err_o, 1'b1);
      check_eq("bad_ack", bus.ack_o, 1'b0);
      check_eq("bad_dat", bus.dat_o, 16'h5A5A);
      step(); idle_bus();
      @(negedge clk);
      check_eq("bad_end", {busy, bus.err_o}, 2'b00);

      // Slave 2 never acks (other slaves' acks asserted and ignored).
      errs = 0; stb_ok = 0;
      step(); drive_req(16'h2000, 1'b0, 16'h0000, 2'b11); slv_ack = 3'b011;
      @(negedge clk);
      for (int c = 1; c <= 8; c++) begin
         step();
         @(negedge clk);
         if (slv_stb == 3'b100) stb_ok++;
         errs += int'(bus.err_o);
      end
      check_eq("to_stb_cycles", stb_ok, 8);
      check_eq("to_no_early_err", errs, 0);
      step();
      @(negedge clk);
      check_eq("to_err", bus.err_o, 1'b1);
      check_eq("to_stb_drop", slv_stb, 3'b000);
      check_eq("to_ack", bus.ack_o, 1'b0);
      step(); idle_bus(); slv_ack = '0;
      @(negedge clk);
      check_eq("to_err_once", bus.err_o, 1'b0);

      // Slave 2 acks exactly on ACTIVE cycle 8: ack wins over timeout.
      errs = 0;
      step(); drive_req(16'h2000, 1'b0, 16'h0000, 2'b11); slv_dat[47:32] = 16'hC0DE;
      @(negedge clk);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 8) slv_ack = 3'b100;
         @(negedge clk);
         errs += int'(bus.err_o);
      end
      step(); slv_ack = '0;
      @(negedge clk);
      errs += int'(bus.err_o);
      check_eq("to8_ack", bus.ack_o, 1'b1);
      check_eq("to8_no_err", errs, 0);
      check_eq("to8_dat", bus.dat_o, 16'hC0DE);
      step(); idle_bus();
      @(negedge clk);

      // Master abort in ACTIVE cycle 3.
      acks = 0;
      step(); drive_req(16'h1000, 1'b0, 16'h0000, 2'b11);
      @(negedge clk);
      step(); @(negedge clk);
      step(); @(negedge clk);
      step(); idle_bus();
      @(negedge clk);
      check_eq("abort_stb", {slv_cyc, slv_stb}, 6'b0);
      check_eq("abort_busy_c3", busy, 1'b1);
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         acks += int'(bus.ack_o) + int'(bus.err_o);
      end
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_no_resp", acks, 0);

      // Reset while ACTIVE, with the slave acking during reset.
      acks = 0;
      step(); drive_req(16'h2000, 1'b0, 16'h0000, 2'b11);
      @(negedge clk);
      step();
      @(negedge clk);
      check_eq("rstx_stb_pre", slv_stb, 3'b100);
      step(); rst = 1'b1; slv_ack = 3'b100;
      @(negedge clk);
      check_eq("rstx_stb", {slv_cyc, slv_stb}, 6'b0);
      check_eq("rstx_busy", busy, 1'b0);
      step(); rst = 1'b0; slv_ack = '0; idle_bus();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         acks += int'(bus.ack_o) + int'(bus.err_o) + int'(busy);
         step();
      end
      check_eq("rstx_quiet", acks, 0);

      // Normal request after abort and reset.
      read_txn("post", 16'h2000, 2, 16'h7777, 3'b100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
